// File: rtl/snake_pkg.sv
// Shared definitions for the snake head stepper: direction encoding,
// controller states and the opposite-direction helper.
package snake_pkg;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      RIGHT = 2'd2,
      LEFT  = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DEAD = 2'd2
   } state_t;

   function automatic dir_t opposite(input dir_t d);
      dir_t r;
      case (d)
         UP:      r = DOWN;
         DOWN:    r = UP;
         RIGHT:   r = LEFT;
         default: r = RIGHT;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/snake_dir_queue.sv
// Two-entry FIFO of pending direction changes. A same-cycle pop and push
// removes the head first and places the new entry behind whatever remains.
module snake_dir_queue
   import snake_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  dir_t       din,
   output dir_t       head,
   output dir_t       tail,
   output logic [1:0] count,
   output logic       full
);

   dir_t       entry0;
   dir_t       entry1;
   logic       pop_eff;
   logic       push_eff;

   assign pop_eff  = pop && (count != 2'd0);
   assign push_eff = push && ((count != 2'd2) || pop_eff);

   assign head = entry0;
   assign tail = (count == 2'd2) ? entry1 : entry0;
   assign full = (count == 2'd2);

   // NOTE: non-blocking (<=) for every flop so all registers update from
   // the same pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count <= 2'd0;
      end else begin
         case ({push_eff, pop_eff})
            2'b01:   count <= count - 2'd1;
            2'b10:   count <= count + 2'd1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the entry storage has no reset; count alone says which entries
   // are valid, so clearing the data would only cost reset fan-out.
   always_ff @(posedge clk) begin
      case ({push_eff, pop_eff})
         2'b01: entry0 <= entry1;
         2'b10: begin
            if (count == 2'd0) entry0 <= din;
            else               entry1 <= din;
         end
         2'b11: begin
            if (count == 2'd2) begin
               entry0 <= entry1;
               entry1 <= din;
            end else begin
               entry0 <= din;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head controller: IDLE/RUN/DEAD state machine, queued direction
// changes and one-cell moves per step tick with wall-kill or toroidal wrap.
module snake_head_stepper
   import snake_pkg::*;
#(
   parameter int GRID_ROWS = 48,
   parameter int GRID_COLS = 64,
   parameter int COORD_W   = 7,
   parameter int START_X   = 24,
   parameter int START_Y   = 32,
   parameter int START_WAY = 2,
   parameter int WRAP      = 0
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   input  logic               i_Start,
   input  logic               i_Step,
   input  logic               i_Push_Valid,
   input  logic [1:0]         i_Push,
   output logic [COORD_W-1:0] o_Head_x,
   output logic [COORD_W-1:0] o_Head_y,
   output logic [1:0]         o_Way,
   output logic               o_Step_Done,
   output logic               o_Dead,
   output logic               o_Q_Full
);

   localparam logic [COORD_W:0]   ONE_EXT     = {{COORD_W{1'b0}}, 1'b1};
   localparam logic [COORD_W:0]   ROW_LIM     = GRID_ROWS[COORD_W:0];
   localparam logic [COORD_W:0]   COL_LIM     = GRID_COLS[COORD_W:0];
   localparam logic [COORD_W-1:0] START_X_C   = START_X[COORD_W-1:0];
   localparam logic [COORD_W-1:0] START_Y_C   = START_Y[COORD_W-1:0];
   localparam dir_t               START_WAY_C = dir_t'(START_WAY[1:0]);

   state_t             state;
   dir_t               way;

   logic               do_step;
   logic               q_push;
   logic               q_pop;
   logic               q_flush;
   dir_t               q_head;
   dir_t               q_tail;
   logic [1:0]         q_count;
   logic               q_full;
   logic [1:0]         post_count;
   dir_t               move_dir;
   dir_t               ref_dir;
   dir_t               push_dir;

   logic [COORD_W:0]   x_ext;
   logic [COORD_W:0]   y_ext;
   logic [COORD_W:0]   nx_ext;
   logic [COORD_W:0]   ny_ext;
   logic               off_grid;

   snake_dir_queue u_queue (
      .clk   (i_Clk),
      .rst   (i_Rst),
      .flush (q_flush),
      .push  (q_push),
      .pop   (q_pop),
      .din   (push_dir),
      .head  (q_head),
      .tail  (q_tail),
      .count (q_count),
      .full  (q_full)
   );

   assign o_Way    = way;
   assign o_Q_Full = q_full;

   // A push is judged against the queue as it stands after this cycle's pop.
   always_comb begin
      do_step    = (state == S_RUN) && i_Step;
      q_pop      = do_step && (q_count != 2'd0);
      move_dir   = q_pop ? q_head : way;
      post_count = q_count - {1'b0, q_pop};
      ref_dir    = (post_count != 2'd0) ? q_tail : move_dir;
      push_dir   = dir_t'(i_Push);
      q_push     = (state == S_RUN) && i_Push_Valid && (post_count != 2'd2) &&
                   (push_dir != ref_dir) && (push_dir != opposite(ref_dir));
      q_flush    = i_Start && (state == S_DEAD);
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      x_ext    = {1'b0, o_Head_x};
      y_ext    = {1'b0, o_Head_y};
      nx_ext   = x_ext;
      ny_ext   = y_ext;
      off_grid = 1'b0;
      case (move_dir)
         UP: begin
            nx_ext   = x_ext - ONE_EXT;
            off_grid = nx_ext[COORD_W];
            if (off_grid && (WRAP != 0)) nx_ext = ROW_LIM - ONE_EXT;
         end
         DOWN: begin
            nx_ext   = x_ext + ONE_EXT;
            off_grid = (nx_ext >= ROW_LIM);
            if (off_grid && (WRAP != 0)) nx_ext = '0;
         end
         RIGHT: begin
            ny_ext   = y_ext + ONE_EXT;
            off_grid = (ny_ext >= COL_LIM);
            if (off_grid && (WRAP != 0)) ny_ext = '0;
         end
         default: begin
            ny_ext   = y_ext - ONE_EXT;
            off_grid = ny_ext[COORD_W];
            if (off_grid && (WRAP != 0)) ny_ext = COL_LIM - ONE_EXT;
         end
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state       <= S_IDLE;
         o_Head_x    <= START_X_C;
         o_Head_y    <= START_Y_C;
         way         <= START_WAY_C;
         o_Step_Done <= 1'b0;
         o_Dead      <= 1'b0;
      end else begin
         o_Step_Done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (i_Start) begin
                  state    <= S_RUN;
                  o_Head_x <= START_X_C;
                  o_Head_y <= START_Y_C;
                  way      <= START_WAY_C;
               end
            end
            S_RUN: begin
               if (do_step) begin
                  way <= move_dir;
                  if (off_grid && (WRAP == 0)) begin
                     state  <= S_DEAD;
                     o_Dead <= 1'b1;
                  end else begin
                     o_Head_x    <= nx_ext[COORD_W-1:0];
                     o_Head_y    <= ny_ext[COORD_W-1:0];
                     o_Step_Done <= 1'b1;
                  end
               end
            end
            S_DEAD: begin
               if (i_Start) begin
                  state    <= S_RUN;
                  o_Dead   <= 1'b0;
                  o_Head_x <= START_X_C;
                  o_Head_y <= START_Y_C;
                  way      <= START_WAY_C;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
